// File: rtl/ysyx_23060111_lsu_pkg.sv
// Shared LSU definitions: FSM state encoding, RV32I funct3 size codes and request legality helpers.
package ysyx_23060111_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_illegal(input logic wen, input logic [2:0] f3);
    if (wen) return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060111_lsu_if.sv
// LSU bus bundle: EXU request, writeback response and memory request/response channels.
interface ysyx_23060111_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_wen;
  logic        resp_err;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // slave: the LSU itself; master: the surrounding EXU/WBU/memory environment
  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_wen, resp_err,
    input  resp_ready,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_wen, resp_err,
    output resp_ready,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060111_lsu_align.sv
// Combinational lane logic: store byte strobe / data replication and load lane select with extension.
module ysyx_23060111_lsu_align
  import ysyx_23060111_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wmask_o = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wmask_o = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wmask_o = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Half accesses only look at addr[1]; word accesses ignore the lane entirely.
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   rdata_o = {24'd0, byte_sel};
      F3_HU:   rdata_o = {16'd0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one outstanding memory transaction with timeout abort.
// Define YSYX_23060111_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module ysyx_23060111_lsu
  import ysyx_23060111_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_23060111_lsu_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cap_req, cap_rdata, timeout, pre_err;

  logic        wen_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  rd_q;

  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, ext_rdata;

`ifdef YSYX_23060111_MISALIGN_TRAP_EN
  assign pre_err = f3_illegal(bus.req_wen, bus.req_funct3) ||
                   misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign pre_err = f3_illegal(bus.req_wen, bus.req_funct3);
`endif

  // Counter saturates at CNT_LAST so a handshake on the final REQ cycle still times out in WAIT.
  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cap_req   = 1'b0;
    cap_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cap_req = 1'b1;
          err_d   = pre_err;
          cnt_d   = '0;
          state_d = pre_err ? RESP : REQ;
        end
      end
      REQ: begin
        cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
        if (bus.mem_ready && bus.mem_rvalid) begin
          cap_rdata = 1'b1;
          state_d   = RESP;
        end else if (bus.mem_ready) begin
          state_d = WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
        if (bus.mem_rvalid) begin
          cap_rdata = 1'b1;
          state_d   = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Payload registers carry no reset: every output they feed is gated by the FSM state.
  always_ff @(posedge clk) begin
    if (cap_req) begin
      wen_q   <= bus.req_wen;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rd_q    <= bus.req_rd;
    end
    if (cap_rdata) rdata_q <= bus.mem_rdata;
  end

  ysyx_23060111_lsu_align u_align (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (rdata_q),
    .wmask_o  (lane_mask),
    .wdata_o  (lane_wdata),
    .rdata_o  (ext_rdata)
  );

  logic in_req, in_resp, st_req, load_ok;
  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);
  assign st_req  = in_req && wen_q;
  assign load_ok = !err_q && !wen_q;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_valid  = in_req;
  assign bus.mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.mem_wen    = st_req;
  assign bus.mem_wmask  = st_req ? lane_mask : 4'b0000;
  assign bus.mem_wdata  = st_req ? lane_wdata : 32'd0;
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = (in_resp && load_ok) ? ext_rdata : 32'd0;
  assign bus.resp_rd    = in_resp ? rd_q : 5'd0;
  assign bus.resp_wen   = in_resp && load_ok && (rd_q != 5'd0);
  assign bus.resp_err   = in_resp && err_q;

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Randomized bench for the LSU with a transaction-level reference model and per-cycle comparison.
`timescale 1ns/1ps
module tb_ysyx_23060111_lsu;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060111_lsu_if bus();
  ysyx_23060111_lsu #(.TIMEOUT_CYC(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_req_ready, exp_mem_valid, exp_resp_valid, exp_zero;
  logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
  logic [3:0]  exp_mwmask;
  logic        exp_mwen, exp_rwen, exp_rerr, exp_chk_rdata;
  logic [4:0]  exp_rd;

  int          mv_total = 0;
  int          rv_total = 0;
  logic [31:0] last_maddr, last_mwdata, last_rdata;
  logic [3:0]  last_mwmask;
  logic        last_rwen, last_rerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_base(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    return (int'(a[1:0]) / sz) * sz;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int base, sz;
    sz = m_size(f3);
    base = m_base(f3, a);
    for (int b = 0; b < 4; b++) m[b] = (b >= base) && (b < base + sz);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int sz;
    sz = m_size(f3);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] md);
    logic [31:0] v, lim;
    int sz, bits;
    sz = m_size(f3);
    v = md >> (8 * m_base(f3, a));
    if (sz == 4) return v;
    bits = 8 * sz;
    lim = (32'h1 << bits) - 32'h1;
    v = v & lim;
    if (!f3[2] && v[bits-1]) v = v | ~lim;
    return v;
  endfunction

  function automatic logic m_pre_err(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    logic e;
    if (wen) e = (f3 > 3'd2);
    else     e = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
    if (!e && (int'(a[1:0]) % m_size(f3)) != 0) e = 1'b1;
`else
    if (a[31]) e = e;
`endif
    return e;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (bus.mem_valid) mv_total++;
    if (bus.resp_valid) rv_total++;
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_req_ready));
      chk("mem_valid", 32'(bus.mem_valid), 32'(exp_mem_valid));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp_valid));
      if (exp_mem_valid) begin
        chk("mem_addr", bus.mem_addr, exp_maddr);
        chk("mem_wen", 32'(bus.mem_wen), 32'(exp_mwen));
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(exp_mwmask));
        if (exp_mwen) chk("mem_wdata", bus.mem_wdata, exp_mwdata);
        last_maddr  = bus.mem_addr;
        last_mwmask = bus.mem_wmask;
        last_mwdata = bus.mem_wdata;
      end
      if (exp_resp_valid) begin
        if (exp_chk_rdata) chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_rd", 32'(bus.resp_rd), 32'(exp_rd));
        chk("resp_wen", 32'(bus.resp_wen), 32'(exp_rwen));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_rerr));
        last_rdata = bus.resp_rdata;
        last_rwen  = bus.resp_wen;
        last_rerr  = bus.resp_err;
      end
      if (exp_zero) begin
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
        chk("rst_resp_wen", 32'(bus.resp_wen), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req_ready  = 1'b1;
    exp_mem_valid  = 1'b0;
    exp_resp_valid = 1'b0;
  endtask

  // d1: REQ cycles before mem_ready; d2: WAIT cycles before mem_rvalid (0 = same cycle as mem_ready);
  // rr: cycles resp_ready held low; rst_at: WAIT cycle index that pulses reset (-1 = none).
  task automatic do_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] mrdata,
                        input int d1, input int d2, input int rr, input int gap, input int rst_at);
    logic pre_err, timed_out, done, in_wait, err;
    int k;
    pre_err = m_pre_err(wen, f3, addr);
    set_idle_exp();
    bus.resp_ready = 1'b0;
    bus.mem_ready  = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      step();
    end
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    bus.mem_rvalid = 1'b0;
    step();
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom_range(0, 31));
    exp_req_ready  = 1'b0;
    timed_out = 1'b0;
    if (!pre_err) begin
      exp_maddr  = {addr[31:2], 2'b00};
      exp_mwen   = wen;
      exp_mwmask = wen ? m_mask(f3, addr) : 4'b0000;
      exp_mwdata = m_wdata(f3, wdata);
      done = 1'b0;
      in_wait = 1'b0;
      k = 0;
      while (!done) begin
        if (!in_wait) begin
          exp_mem_valid = 1'b1;
          bus.mem_ready = (k == d1);
          if (k == d1) begin
            bus.mem_rvalid = (d2 == 0);
            bus.mem_rdata  = (d2 == 0) ? mrdata : $urandom;
          end else begin
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
          end
          step();
          if (k == d1) begin
            if (d2 == 0) done = 1'b1;
            else in_wait = 1'b1;
          end else if (k >= T - 1) begin
            done = 1'b1;
            timed_out = 1'b1;
          end
        end else begin
          exp_mem_valid = 1'b0;
          bus.mem_ready = 1'b0;
          if (rst_at >= 0 && (k - d1) == rst_at) begin
            rst_n = 1'b0;
            bus.mem_rvalid = 1'b0;
            set_idle_exp();
            exp_zero = 1'b1;
            step();
            rst_n = 1'b1;
            exp_zero = 1'b0;
            return;
          end
          bus.mem_rvalid = ((k - d1) == d2);
          bus.mem_rdata  = ((k - d1) == d2) ? mrdata : $urandom;
          step();
          if ((k - d1) == d2) begin
            done = 1'b1;
          end else if (k >= T - 1) begin
            done = 1'b1;
            timed_out = 1'b1;
          end
        end
        k++;
      end
    end
    err = pre_err || timed_out;
    exp_mem_valid  = 1'b0;
    exp_resp_valid = 1'b1;
    exp_rd         = rd;
    exp_rerr       = err;
    exp_rwen       = !err && !wen && (rd != 5'd0);
    exp_chk_rdata  = err || !wen;
    exp_rdata      = err ? 32'd0 : m_load(f3, addr, mrdata);
    bus.mem_ready  = 1'b0;
    for (int i = 0; i <= rr; i++) begin
      bus.resp_ready = (i == rr);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      step();
    end
    bus.resp_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    set_idle_exp();
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 5000000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv0, rv0;
    logic w;
    logic [2:0] f;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_rd = 5'd0; bus.resp_ready = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    exp_zero = 1'b0; exp_chk_rdata = 1'b0;
    exp_maddr = 0; exp_mwdata = 0; exp_rdata = 0; exp_mwmask = 0;
    exp_mwen = 0; exp_rwen = 0; exp_rerr = 0; exp_rd = 0;
    set_idle_exp();
    step(); step();
    rst_n = 1'b1;
    exp_zero = 1'b1;
    chk_en = 1'b1;
    step(); step();
    exp_zero = 1'b0;

    // LB / LBU sign and zero extension from lane 3
    do_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 32'h8012_3456, 0, 1, 0, 0, -1);
    chk("lit_lb_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lit_lb_wen", 32'(last_rwen), 32'd1);
    do_txn(1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd5, 32'h8012_3456, 0, 1, 0, 0, -1);
    chk("lit_lbu_rdata", last_rdata, 32'h0000_0080);

    // SH to the upper half
    do_txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 5'd7, 32'h0, 0, 1, 0, 1, -1);
    chk("lit_sh_addr", last_maddr, 32'h8000_0000);
    chk("lit_sh_mask", 32'(last_mwmask), 32'h0000_000C);
    chk("lit_sh_wdata", last_mwdata, 32'hABCD_ABCD);
    chk("lit_sh_wen", 32'(last_rwen), 32'd0);

    // mem_ready never arrives: abort after T REQ cycles
    mv0 = mv_total;
    do_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd3, 32'h5555_AAAA, 100, 1, 0, 0, -1);
    chk("lit_to_mvcycles", 32'(mv_total - mv0), 32'd4);
    chk("lit_to_err", 32'(last_rerr), 32'd1);
    chk("lit_to_rdata", last_rdata, 32'd0);

    // misaligned word load
    mv0 = mv_total;
    do_txn(1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 1, 0, 0, -1);
`ifdef YSYX_23060111_MISALIGN_TRAP_EN
    chk("lit_mis_mvcycles", 32'(mv_total - mv0), 32'd0);
    chk("lit_mis_err", 32'(last_rerr), 32'd1);
`else
    chk("lit_mis_addr", last_maddr, 32'h8000_0000);
    chk("lit_mis_err", 32'(last_rerr), 32'd0);
    chk("lit_mis_rdata", last_rdata, 32'hCAFE_F00D);
`endif

    // illegal funct3 for load and store
    mv0 = mv_total;
    do_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd4, 32'h1, 0, 0, 0, 0, -1);
    do_txn(1'b1, 3'b100, 32'h8000_0000, 32'h1, 5'd4, 32'h1, 0, 0, 0, 0, -1);
    chk("lit_ill_mvcycles", 32'(mv_total - mv0), 32'd0);
    chk("lit_ill_err", 32'(last_rerr), 32'd1);

    // reset mid-WAIT, then a clean transaction
    do_txn(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd6, 32'h1111_2222, 0, 3, 0, 0, 1);
    mv0 = mv_total;
    do_txn(1'b0, 3'b010, 32'h8000_0024, 32'h0, 5'd6, 32'h3333_4444, 0, 1, 0, 0, -1);
    chk("lit_postrst_mv", 32'(mv_total - mv0), 32'd1);
    chk("lit_postrst_rdata", last_rdata, 32'h3333_4444);

    // writeback back-pressure for 3 cycles
    rv0 = rv_total;
    do_txn(1'b0, 3'b001, 32'h8000_0006, 32'h0, 5'd1, 32'h8001_7FFF, 0, 0, 3, 0, -1);
    chk("lit_bp_rvcycles", 32'(rv_total - rv0), 32'd4);
    chk("lit_bp_rdata", last_rdata, 32'hFFFF_8001);

    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else if (w) f = st_f3[$urandom_range(0, 2)];
      else f = ld_f3[$urandom_range(0, 4)];
      do_txn(w, f, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom,
             5'($urandom_range(0, 31)), $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060111_lsu.md
YSYX_23060111_LSU -- requirements
Module: ysyx_23060111_LSU

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL be the cycle limit for one memory transaction before abort.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_valid  in  1  SHALL mean that an EXU load/store request is present.
REQ-005 req_ready  out  1  SHALL mean that the LSU accepts a request this cycle.
REQ-006 req_wen  in  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  in  3  SHALL carry the RV32I size/sign code.
REQ-008 req_addr  in  32  SHALL carry the byte address; req_wdata  in  32  SHALL carry the store data (rs2).
REQ-009 req_rd  in  5  SHALL carry the load destination register.
REQ-010 resp_valid  out  1 and resp_ready  in  1  SHALL form the result handshake to writeback.
REQ-011 resp_rdata  out  32, resp_rd  out  5, resp_wen  out  1, resp_err  out  1  SHALL carry the result, destination, register-write enable and error flag.
REQ-012 mem_valid  out  1 and mem_ready  in  1  SHALL form the memory request handshake.
REQ-013 mem_addr  out  32 (word-aligned, [1:0]=0), mem_wen  out  1, mem_wdata  out  32, mem_wmask  out  4  SHALL form the request payload; mem_wmask is a byte strobe.
REQ-014 mem_rvalid  in  1 and mem_rdata  in  32  SHALL form the memory response, for loads and for store acknowledge alike.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE transition: req_valid=1 captures all req_* and moves to REQ; illegal or misaligned requests (REQ-023, REQ-024) move directly to RESP.
REQ-017 REQ transition: mem_valid=1 with a stable payload; mem_ready=1 moves to WAIT.
REQ-018 WAIT transition: mem_rvalid=1 captures the data and moves to RESP; mem_rvalid in any other state SHALL be ignored.
REQ-019 RESP transition: resp_valid=1 and outputs are held stable; resp_ready=1 moves to IDLE.
REQ-020 Best-case latency: accept at cycle N, mem_valid at N+1 (mem_ready=1), mem_rvalid at N+2, resp_valid at N+3.
REQ-021 funct3 decode SHALL be 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; LB/LH sign-extend, LBU/LHU zero-extend, from lane addr[1:0].
REQ-022 Store encoding: SB mask 0001<<addr[1:0] with data {4{b}}; SH mask 0011<<{addr[1],0} with data {2{h}}; SW mask 1111; loads drive mask 0000, mem_wen 0.
REQ-023 An illegal funct3 (loads: 011, 110, 111; stores: >010) SHALL produce no memory access and resp_err=1.
REQ-024 An error response SHALL carry resp_err=1, resp_rdata=0 and resp_wen=0.
REQ-025 resp_wen SHALL be 1 only for an error-free load with rd≠0; resp_rd SHALL echo req_rd.
REQ-026 Timeout: a counter cleared on entering REQ SHALL increment in REQ and WAIT; on reaching TIMEOUT_CYC the block drops mem_valid and goes to RESP with resp_err=1.
REQ-027 When mem_ready and mem_rvalid are both 1 in the same REQ cycle, the LSU SHALL take both and go directly to RESP.

Reset
REQ-028 rst_n=0 SHALL force IDLE asynchronously, including mid-transaction; the in-flight request is discarded.
REQ-029 Reset values SHALL be: req_ready=1 once reset is released, and all other outputs 0 (mem_valid, resp_valid, mem_wen, resp_wen, resp_err, mem_wmask, data and address buses).

Configuration
REQ-030 Macro YSYX_23060111_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]≠0 SHALL produce no memory access and resp_err=1.
REQ-031 Macro undefined: misaligned low bits SHALL be ignored (half uses addr[1], word ignores addr[1:0]) and no error is raised.

Structure
REQ-032 FSM state encodings and funct3 size codes SHALL live in the shared ysyx_23060111 defines package.
REQ-033 Lane shift, mask generation and load extension SHALL be a combinational sub-module ysyx_23060111_LSU_ALIGN.

Verification
REQ-034 LB addr 0x80000003, mem_rdata 0x80xxxxxx -> resp_rdata 0xFFFFFF80, resp_wen=1; LBU on the same data -> 0x00000080.
REQ-035 SH addr 0x80000002 data 0x1234ABCD -> mem_addr 0x80000000, mem_wmask 1100, mem_wdata 0xABCDABCD, resp_wen=0.
REQ-036 mem_ready held 0 with TIMEOUT_CYC=4 -> resp_err=1 exactly 4 cycles after entering REQ; a later mem_rvalid is ignored.
REQ-037 LW addr 0x80000001 -> with the macro: no mem_valid and resp_err=1; without it: mem_addr 0x80000000 and resp_err=0.
REQ-038 rst_n pulsed low in WAIT -> immediate IDLE with all outputs 0; the next request completes normally.
REQ-039 resp_ready held 0 for 3 cycles -> resp_valid and payload stay stable and req_ready stays 0.
